// File: rtl/mem_bus_ctrl_if.sv
// CPU and memory-side signal bundle for mem_bus_ctrl.
// The slave modport is the controller; the master modport is the CPU plus the RAM/ROM arrays.
interface mem_bus_ctrl_if #(
    parameter int RAM_AW = 12,
    parameter int ROM_AW = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ready;
    logic              ram_cs;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              rom_cs;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_rdata;
    logic              bus_err;
    logic              err_clr;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, rom_rdata, err_clr,
        output cpu_rdata, cpu_ready, ram_cs, ram_we, ram_addr, ram_wdata, rom_cs, rom_addr, bus_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, rom_rdata, err_clr,
        input  cpu_rdata, cpu_ready, ram_cs, ram_we, ram_addr, ram_wdata, rom_cs, rom_addr, bus_err
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// 6502 memory-port bus controller: decodes RAM/ROM/unmapped space, inserts
// per-region wait states, returns read data with a one-cycle ready pulse.
module mem_bus_ctrl #(
    parameter int         RAM_AW        = 12,
    parameter int         ROM_AW        = 12,
    parameter int         RAM_WS        = 0,
    parameter int         ROM_WS        = 1,
    parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
    input  logic          ph2,
    input  logic          resetb,
    mem_bus_ctrl_if.slave bus
);
    localparam logic [16:0] RAM_TOP  = 17'(1 << RAM_AW);
    localparam logic [16:0] ROM_BASE = 17'(65536 - (1 << ROM_AW));

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_NONE} region_t;

    state_t            r_state;
    region_t           r_region;
    logic              r_we;
    logic [3:0]        r_cnt;
    logic [7:0]        r_rdata;
    logic              r_ready;
    logic              r_ram_cs;
    logic              r_ram_we;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [7:0]        r_ram_wdata;
    logic              r_rom_cs;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_bus_err;

    region_t w_region;
    logic    w_illegal;

    always_comb begin
        w_region = REG_NONE;
        if ({1'b0, bus.cpu_addr} < RAM_TOP)
            w_region = REG_RAM;
        else if ({1'b0, bus.cpu_addr} >= ROM_BASE)
            w_region = REG_ROM;
    end

    // ROM writes and anything outside both arrays raise the sticky error.
    assign w_illegal = (w_region == REG_NONE) || ((w_region == REG_ROM) && bus.cpu_we);

    // Strobes are registered on the request edge so they are visible exactly during ACCESS.
    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            r_state     <= S_IDLE;
            r_region    <= REG_NONE;
            r_we        <= 1'b0;
            r_cnt       <= 4'd0;
            r_rdata     <= 8'd0;
            r_ready     <= 1'b0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 8'd0;
            r_rom_cs    <= 1'b0;
            r_rom_addr  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_ram_cs <= 1'b0;
            r_ram_we <= 1'b0;
            r_rom_cs <= 1'b0;
            r_ready  <= 1'b0;
            if (bus.err_clr)
                r_bus_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        r_state     <= S_ACCESS;
                        r_region    <= w_region;
                        r_we        <= bus.cpu_we;
                        r_ram_addr  <= bus.cpu_addr[RAM_AW-1:0];
                        r_ram_wdata <= bus.cpu_wdata;
                        r_rom_addr  <= bus.cpu_addr[ROM_AW-1:0];
                        r_ram_cs    <= (w_region == REG_RAM);
                        r_ram_we    <= (w_region == REG_RAM) && bus.cpu_we;
                        r_rom_cs    <= (w_region == REG_ROM) && !bus.cpu_we;
                        if (w_illegal)
                            r_bus_err <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    case (r_region)
                        REG_RAM: r_cnt <= 4'(RAM_WS);
                        REG_ROM: r_cnt <= 4'(ROM_WS);
                        default: r_cnt <= 4'd0;
                    endcase
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            case (r_region)
                                REG_RAM: r_rdata <= bus.ram_rdata;
                                REG_ROM: r_rdata <= bus.rom_rdata;
                                default: r_rdata <= UNMAPPED_DATA;
                            endcase
                        end
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_ready = r_ready;
    assign bus.ram_cs    = r_ram_cs;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.rom_cs    = r_rom_cs;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with behavioural RAM/ROM arrays.
module tb_mem_bus_ctrl;
    localparam int RAM_AW = 12;
    localparam int ROM_AW = 12;

    logic ph2 = 1'b0;
    logic resetb = 1'b0;
    always #5 ph2 = ~ph2;

    mem_bus_ctrl_if #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) bus();

    mem_bus_ctrl #(
        .RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .RAM_WS(0), .ROM_WS(2), .UNMAPPED_DATA(8'hFF)
    ) dut (
        .ph2(ph2),
        .resetb(resetb),
        .bus(bus)
    );

    logic [7:0] ram_mem [0:4095];
    logic [7:0] rom_mem [0:4095];

    always @(posedge ph2) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
        if (bus.rom_cs) bus.rom_rdata <= rom_mem[bus.rom_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ram_cs = 0, n_ram_we = 0, n_rom_cs = 0, n_ready = 0;
    logic [11:0] last_ram_addr = '0;
    logic [7:0]  last_ram_wdata = '0;

    always @(posedge ph2) cyc++;

    always @(negedge ph2) begin
        if (bus.ram_cs === 1'b1) begin n_ram_cs++; last_ram_addr = bus.ram_addr; end
        if (bus.ram_we === 1'b1) begin n_ram_we++; last_ram_wdata = bus.ram_wdata; end
        if (bus.rom_cs === 1'b1) n_rom_cs++;
        if (bus.cpu_ready === 1'b1) n_ready++;
    end

    // Issue one request from IDLE (called at a falling edge); returns ready latency in cycles.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                           input logic clr, output int lat, output logic [7:0] rd);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        bus.err_clr = clr;
        @(posedge ph2); #1;
        bus.cpu_req = 1'b0; bus.err_clr = 1'b0;
        lat = -1; rd = 8'h00;
        for (int i = 1; i <= 30; i++) begin
            @(negedge ph2);
            if (bus.cpu_ready === 1'b1) begin lat = i; rd = bus.cpu_rdata; break; end
        end
        @(negedge ph2);
        $display("txn we=%0b addr=%h wdata=%h -> latency=%0d rdata=%h bus_err=%b", we, addr, wdata, lat, rd, bus.bus_err);
    endtask

    task automatic test_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0004; bus.cpu_wdata = 8'hAA;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge ph2);
        checks++; if ({bus.cpu_rdata, bus.cpu_ready, bus.bus_err} !== 10'd0) begin errors++; $display("FAIL reset_cpu_side: got %h required 0", {bus.cpu_rdata, bus.cpu_ready, bus.bus_err}); end
        checks++; if ({bus.ram_cs, bus.ram_we, bus.rom_cs} !== 3'd0) begin errors++; $display("FAIL reset_strobes: got %b required 000", {bus.ram_cs, bus.ram_we, bus.rom_cs}); end
        checks++; if ({bus.ram_addr, bus.ram_wdata, bus.rom_addr} !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %h required 0", {bus.ram_addr, bus.ram_wdata, bus.rom_addr}); end
        bus.cpu_req = 1'b0;
        resetb = 1'b1;
        repeat (2) @(negedge ph2);
        checks++; if (n_ram_cs !== 0) begin errors++; $display("FAIL reset_no_access: ram_cs count %0d required 0", n_ram_cs); end
    endtask

    task automatic test_ram_near();
        int lat; logic [7:0] rd; int c0, w0;
        c0 = n_ram_cs; w0 = n_ram_we;
        run_txn(1'b1, 16'h0004, 8'h75, 1'b0, lat, rd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ram_write_latency: got %0d required 3", lat); end
        checks++; if ((n_ram_cs - c0) !== 1 || (n_ram_we - w0) !== 1) begin errors++; $display("FAIL ram_write_strobes: cs %0d we %0d required 1 1", n_ram_cs - c0, n_ram_we - w0); end
        checks++; if (last_ram_addr !== 12'h004 || last_ram_wdata !== 8'h75) begin errors++; $display("FAIL ram_write_bus: addr %h wdata %h required 004 75", last_ram_addr, last_ram_wdata); end
        w0 = n_ram_we;
        run_txn(1'b0, 16'h0004, 8'h00, 1'b0, lat, rd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ram_read_latency: got %0d required 3", lat); end
        checks++; if (rd !== 8'h75) begin errors++; $display("FAIL ram_read_data: got %h required 75", rd); end
        checks++; if (n_ram_we !== w0) begin errors++; $display("FAIL ram_read_no_we: we count %0d required %0d", n_ram_we, w0); end
    endtask

    task automatic test_ram_far();
        int lat; logic [7:0] rd;
        run_txn(1'b1, 16'h0123, 8'h00, 1'b0, lat, rd);
        run_txn(1'b0, 16'h0123, 8'h00, 1'b0, lat, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL far_read_data: got %h required 00", rd); end
        checks++; if (bus.ram_addr !== 12'h123) begin errors++; $display("FAIL far_ram_addr: got %h required 123", bus.ram_addr); end
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL far_bus_err: got %b required 0", bus.bus_err); end
    endtask

    task automatic test_rom_vector();
        int lat; logic [7:0] rd; int r0;
        r0 = n_rom_cs;
        run_txn(1'b0, 16'hFFFC, 8'h00, 1'b0, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rom_lo_latency: got %0d required 5", lat); end
        checks++; if (rd !== 8'h00 || bus.rom_addr !== 12'hFFC) begin errors++; $display("FAIL rom_lo: data %h addr %h required 00 FFC", rd, bus.rom_addr); end
        run_txn(1'b0, 16'hFFFD, 8'h00, 1'b0, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rom_hi_latency: got %0d required 5", lat); end
        checks++; if (rd !== 8'hF0 || bus.rom_addr !== 12'hFFD) begin errors++; $display("FAIL rom_hi: data %h addr %h required F0 FFD", rd, bus.rom_addr); end
        checks++; if ((n_rom_cs - r0) !== 2) begin errors++; $display("FAIL rom_cs_count: got %0d required 2", n_rom_cs - r0); end
    endtask

    task automatic test_illegal();
        int lat; logic [7:0] rd; int c0, w0, r0;
        c0 = n_ram_cs; w0 = n_ram_we; r0 = n_rom_cs;
        run_txn(1'b1, 16'hF000, 8'h12, 1'b0, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rom_write_latency: got %0d required 5", lat); end
        checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL rom_write_err: got %b required 1", bus.bus_err); end
        run_txn(1'b0, 16'h8000, 8'h00, 1'b0, lat, rd);
        checks++; if (lat !== 3 || rd !== 8'hFF) begin errors++; $display("FAIL unmapped_read: latency %0d data %h required 3 FF", lat, rd); end
        checks++; if (n_ram_cs !== c0 || n_ram_we !== w0 || n_rom_cs !== r0) begin errors++; $display("FAIL illegal_strobes: cs/we/rom deltas %0d %0d %0d required 0 0 0", n_ram_cs - c0, n_ram_we - w0, n_rom_cs - r0); end
        run_txn(1'b0, 16'h0004, 8'h00, 1'b0, lat, rd);
        checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", bus.bus_err); end
        run_txn(1'b0, 16'h8000, 8'h00, 1'b1, lat, rd);
        checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b required 1", bus.bus_err); end
        bus.err_clr = 1'b1;
        @(posedge ph2); #1;
        bus.err_clr = 1'b0;
        @(negedge ph2);
        $display("err_clr pulse alone -> bus_err=%b", bus.bus_err);
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", bus.bus_err); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [7:0] rd; int q0, c0, r0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hFFFD;
        @(posedge ph2); #1;
        bus.cpu_req = 1'b0;
        @(negedge ph2);
        @(negedge ph2);
        resetb = 1'b0;
        #1;
        q0 = n_ready; c0 = n_ram_cs; r0 = n_rom_cs;
        $display("reset asserted mid-WAIT -> rdata=%h rom_addr=%h ram_addr=%h", bus.cpu_rdata, bus.rom_addr, bus.ram_addr);
        checks++; if ({bus.cpu_rdata, bus.cpu_ready, bus.bus_err, bus.ram_cs, bus.ram_we, bus.rom_cs} !== 13'd0) begin errors++; $display("FAIL midop_ctrl_zero: got %h required 0", {bus.cpu_rdata, bus.cpu_ready, bus.bus_err, bus.ram_cs, bus.ram_we, bus.rom_cs}); end
        checks++; if ({bus.ram_addr, bus.ram_wdata, bus.rom_addr} !== 32'd0) begin errors++; $display("FAIL midop_addr_zero: got %h required 0", {bus.ram_addr, bus.ram_wdata, bus.rom_addr}); end
        repeat (4) @(negedge ph2);
        resetb = 1'b1;
        repeat (4) @(negedge ph2);
        checks++; if (n_ready !== q0 || n_ram_cs !== c0 || n_rom_cs !== r0) begin errors++; $display("FAIL midop_no_ready: ready/cs/rom deltas %0d %0d %0d required 0 0 0", n_ready - q0, n_ram_cs - c0, n_rom_cs - r0); end
        run_txn(1'b0, 16'h0004, 8'h00, 1'b0, lat, rd);
        checks++; if (lat !== 3 || rd !== 8'h75) begin errors++; $display("FAIL midop_recover: latency %0d data %h required 3 75", lat, rd); end
    endtask

    task automatic test_back_to_back();
        int t [4]; logic [7:0] d [4]; int idx;
        idx = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
        for (int i = 0; i < 60 && idx < 4; i++) begin
            @(negedge ph2);
            if (bus.cpu_ready === 1'b1) begin
                t[idx] = cyc; d[idx] = bus.cpu_rdata;
                $display("b2b ready %0d at cycle %0d data=%h", idx, cyc, bus.cpu_rdata);
                idx++;
                bus.cpu_addr = 16'(idx);
                if (idx == 4) bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        @(negedge ph2);
        checks++; if (idx !== 4) begin errors++; $display("FAIL b2b_count: got %0d ready pulses required 4", idx); end
        for (int k = 0; k < idx; k++) begin
            checks++; if (d[k] !== 8'(8'h10 + k)) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", k, d[k], 8'(8'h10 + k)); end
            if (k > 0) begin
                checks++; if (t[k] - t[k-1] !== 4) begin errors++; $display("FAIL b2b_spacing%0d: got %0d required 4", k, t[k] - t[k-1]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = 8'h00;
            rom_mem[i] = 8'(i);
        end
        ram_mem[12'h123] = 8'h5A;
        for (int i = 0; i < 4; i++) ram_mem[i] = 8'(8'h10 + i);
        rom_mem[4092] = 8'h00;
        rom_mem[4093] = 8'hF0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
        bus.cpu_wdata = 8'h00; bus.err_clr = 1'b0;

        test_reset();
        test_ram_near();
        test_ram_far();
        test_rom_vector();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
